// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: fetch-stage PC register, imem request handshake and
// redirect resolution for execute-stage control transfers.
// Optional feature: define REDIRECT_CNT_EN to add the redirect_cnt output,
// a free-running count of flush_fd pulses.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic [2:0]  ex_op,
  input  logic [31:0] ex_rs_val,
  input  logic [31:0] ex_rt_val,
  input  logic [25:0] ex_target,
  input  logic [31:0] ex_ext_imm,
  input  logic [31:0] pcE,
  output logic [1:0]  pc_sel,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic [31:0] imem_addr,
  output logic [31:0] pcF,
  output logic        flush_fd
`ifdef REDIRECT_CNT_EN
  ,
  output logic [31:0] redirect_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_PEND  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pcF_q, pcF_d;
  logic [31:0] pendTarget_q, pendTarget_d;
  logic        flushFd_q, flushFd_d;

  logic        redirect;
  logic [31:0] redirectTarget;
  logic [31:0] immShifted;
  logic [31:0] branchTarget;
  logic        accept;

  // A request is live in every state except the post-reset idle cycle.
  assign imem_req  = (state_q != ST_RST);
  assign accept    = imem_req && imem_ready;
  assign imem_addr = pcF_q;
  assign pcF       = pcF_q;
  assign flush_fd  = flushFd_q;

  assign immShifted   = ex_ext_imm << 2;
  assign branchTarget = pcE + 32'd4 + immShifted;

  // Decode the execute-stage op into a redirect request, its target and the pc_sel code.
  always_comb begin
    redirect       = 1'b0;
    redirectTarget = 32'h0;
    pc_sel         = 2'b00;
    if (ex_valid) begin
      case (ex_op)
        3'd1, 3'd2: begin
          redirect       = 1'b1;
          pc_sel         = 2'b01;
          redirectTarget = {pcE[31:28], ex_target, 2'b00};
        end
        3'd3, 3'd4: begin
          redirect       = 1'b1;
          pc_sel         = 2'b10;
          redirectTarget = ex_rs_val;
        end
        3'd5: begin
          if (ex_rs_val == ex_rt_val) begin
            redirect       = 1'b1;
            pc_sel         = 2'b11;
            redirectTarget = branchTarget;
          end
        end
        3'd6: begin
          if (ex_rs_val != ex_rt_val) begin
            redirect       = 1'b1;
            pc_sel         = 2'b11;
            redirectTarget = branchTarget;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next PC and state: a redirect either lands now or parks in the pending slot
  // so the outstanding request address never changes mid-handshake.
  always_comb begin
    state_d      = state_q;
    pcF_d        = pcF_q;
    pendTarget_d = pendTarget_q;
    flushFd_d    = redirect;
    if (redirect) begin
      if ((accept || !imem_req) && !stall) begin
        pcF_d   = redirectTarget;
        state_d = ST_FETCH;
      end else begin
        pendTarget_d = redirectTarget;
        state_d      = ST_PEND;
      end
    end else begin
      case (state_q)
        ST_RST: begin
          if (!stall) begin
            state_d = ST_FETCH;
          end
        end
        ST_PEND: begin
          if (accept && !stall) begin
            pcF_d        = pendTarget_q;
            pendTarget_d = 32'h0;
            state_d      = ST_FETCH;
          end
        end
        default: begin
          if (accept && !stall) begin
            pcF_d   = pcF_q + 32'd4;
            state_d = ST_FETCH;
          end else if (!imem_ready) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_FETCH;
          end
        end
      endcase
    end
  end

  // State, PC, pending target and flush registers; reset discards any parked redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_RST;
      pcF_q        <= RESET_PC;
      pendTarget_q <= 32'h0;
      flushFd_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pcF_q        <= pcF_d;
      pendTarget_q <= pendTarget_d;
      flushFd_q    <= flushFd_d;
    end
  end

`ifdef REDIRECT_CNT_EN
  logic [31:0] redirectCnt_q;

  assign redirect_cnt = redirectCnt_q;

  // Count every cycle in which the F/D flush pulse is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirectCnt_q <= 32'h0;
    end else if (flushFd_q) begin
      redirectCnt_q <= redirectCnt_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Testbench for fetch_pc_ctrl: table-driven vectors with a scoreboard queue,
// plus hand-written stall/pending and asynchronous-reset sequences.
module tb_fetch_pc_ctrl;

  typedef struct {
    string       name;
    logic        stall;
    logic        ready;
    logic        exValid;
    logic [2:0]  exOp;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [25:0] tgt;
    logic [31:0] imm;
    logic [31:0] pcE;
    logic [1:0]  expSel;
    logic [31:0] expPc;
    logic        expReq;
    logic        expFlush;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        req;
    logic        flush;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        ex_valid;
  logic [2:0]  ex_op;
  logic [31:0] ex_rs_val;
  logic [31:0] ex_rt_val;
  logic [25:0] ex_target;
  logic [31:0] ex_ext_imm;
  logic [31:0] pcE;
  logic [1:0]  pc_sel;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_addr;
  logic [31:0] pcF;
  logic        flush_fd;
`ifdef REDIRECT_CNT_EN
  logic [31:0] redirect_cnt;
`endif

  int   checks   = 0;
  int   failures = 0;
  int   flushSeen;
  exp_t scoreboard[$];
  vec_t vecs[$];

  fetch_pc_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .ex_valid   (ex_valid),
    .ex_op      (ex_op),
    .ex_rs_val  (ex_rs_val),
    .ex_rt_val  (ex_rt_val),
    .ex_target  (ex_target),
    .ex_ext_imm (ex_ext_imm),
    .pcE        (pcE),
    .pc_sel     (pc_sel),
    .imem_req   (imem_req),
    .imem_ready (imem_ready),
    .imem_addr  (imem_addr),
    .pcF        (pcF),
    .flush_fd   (flush_fd)
`ifdef REDIRECT_CNT_EN
    ,
    .redirect_cnt (redirect_cnt)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(string name, logic st, logic rdy, logic v, logic [2:0] op,
                                 logic [31:0] rs, logic [31:0] rt, logic [25:0] tgt,
                                 logic [31:0] imm, logic [31:0] pce, logic [1:0] sel,
                                 logic [31:0] pc, logic fl);
    vec_t r;
    r.name = name; r.stall = st; r.ready = rdy; r.exValid = v; r.exOp = op;
    r.rs = rs; r.rt = rt; r.tgt = tgt; r.imm = imm; r.pcE = pce;
    r.expSel = sel; r.expPc = pc; r.expReq = 1'b1; r.expFlush = fl;
    return r;
  endfunction

  task automatic checkVal(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the post-edge expectation and check the
  // combinational pc_sel before the edge.
  task automatic applyStimulus(vec_t v);
    exp_t e;
    stall      = v.stall;
    imem_ready = v.ready;
    ex_valid   = v.exValid;
    ex_op      = v.exOp;
    ex_rs_val  = v.rs;
    ex_rt_val  = v.rt;
    ex_target  = v.tgt;
    ex_ext_imm = v.imm;
    pcE        = v.pcE;
    e.name  = v.name;
    e.pc    = v.expPc;
    e.req   = v.expReq;
    e.flush = v.expFlush;
    scoreboard.push_back(e);
    #2;
    checkVal({v.name, ".pc_sel"}, {30'h0, pc_sel}, {30'h0, v.expSel});
  endtask

  // Pop the oldest expectation after the edge and compare registered outputs.
  task automatic checkOutput();
    exp_t e;
    if (scoreboard.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard: actual=empty required=entry");
    end else begin
      e = scoreboard.pop_front();
      checkVal({e.name, ".imem_addr"}, imem_addr, e.pc);
      checkVal({e.name, ".pcF"}, pcF, e.pc);
      checkVal({e.name, ".imem_req"}, {31'h0, imem_req}, {31'h0, e.req});
      checkVal({e.name, ".flush_fd"}, {31'h0, flush_fd}, {31'h0, e.flush});
    end
  endtask

  task automatic step(vec_t v);
    applyStimulus(v);
    @(posedge clk);
    #1;
    checkOutput();
    flushSeen += int'(flush_fd);
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; imem_ready = 1'b0; ex_valid = 1'b0; ex_op = 3'd0;
    ex_rs_val = 32'h0; ex_rt_val = 32'h0; ex_target = 26'h0; ex_ext_imm = 32'h0; pcE = 32'h0;
    flushSeen = 0;

    // Reset values while rst is held low.
    #3;
    checkVal("reset.pcF", pcF, 32'h0);
    checkVal("reset.imem_req", {31'h0, imem_req}, 32'h0);
    checkVal("reset.pc_sel", {30'h0, pc_sel}, 32'h0);
    checkVal("reset.flush_fd", {31'h0, flush_fd}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    //                name      st  rdy v  op    rs            rt      tgt         imm           pcE           sel    pc            fl
    vecs.push_back(mkVec("rstRel", 0, 1, 0, 3'd0, 32'h0,        32'h0,  26'h0,      32'h0,        32'h0,        2'b00, 32'h0,        0));
    vecs.push_back(mkVec("seq4",   0, 1, 0, 3'd0, 32'h0,        32'h0,  26'h0,      32'h0,        32'h0,        2'b00, 32'h4,        0));
    vecs.push_back(mkVec("seq8",   0, 1, 0, 3'd0, 32'h0,        32'h0,  26'h0,      32'h0,        32'h0,        2'b00, 32'h8,        0));
    vecs.push_back(mkVec("wait1",  0, 0, 0, 3'd0, 32'h0,        32'h0,  26'h0,      32'h0,        32'h0,        2'b00, 32'h8,        0));
    vecs.push_back(mkVec("wait2",  0, 0, 0, 3'd0, 32'h0,        32'h0,  26'h0,      32'h0,        32'h0,        2'b00, 32'h8,        0));
    vecs.push_back(mkVec("wait3",  0, 0, 0, 3'd0, 32'h0,        32'h0,  26'h0,      32'h0,        32'h0,        2'b00, 32'h8,        0));
    vecs.push_back(mkVec("seqC",   0, 1, 0, 3'd0, 32'h0,        32'h0,  26'h0,      32'h0,        32'h0,        2'b00, 32'hC,        0));
    vecs.push_back(mkVec("seq10",  0, 1, 0, 3'd0, 32'h0,        32'h0,  26'h0,      32'h0,        32'h0,        2'b00, 32'h10,       0));
    vecs.push_back(mkVec("jal",    0, 1, 1, 3'd2, 32'h0,        32'h0,  26'h40,     32'h0,        32'h1000_0010,2'b01, 32'h1000_0100,1));
    vecs.push_back(mkVec("jalEnd", 0, 0, 0, 3'd0, 32'h0,        32'h0,  26'h0,      32'h0,        32'h0,        2'b00, 32'h1000_0100,0));
    vecs.push_back(mkVec("beqT",   0, 1, 1, 3'd5, 32'h5,        32'h5,  26'h0,      32'hFFFF_FFFE,32'h20,       2'b11, 32'h1C,       1));
    vecs.push_back(mkVec("bneNT",  0, 1, 1, 3'd6, 32'h5,        32'h5,  26'h0,      32'hFFFF_FFFE,32'h20,       2'b00, 32'h20,       0));
    vecs.push_back(mkVec("beqNT",  0, 1, 1, 3'd5, 32'h5,        32'h6,  26'h0,      32'hFFFF_FFFE,32'h20,       2'b00, 32'h24,       0));
    vecs.push_back(mkVec("op7",    0, 1, 1, 3'd7, 32'h5,        32'h6,  26'h3,      32'h1,        32'h20,       2'b00, 32'h28,       0));
    vecs.push_back(mkVec("noValid",0, 1, 0, 3'd2, 32'h0,        32'h0,  26'h40,     32'h0,        32'h1000_0010,2'b00, 32'h2C,       0));
    vecs.push_back(mkVec("bneT",   0, 1, 1, 3'd6, 32'h1,        32'h2,  26'h0,      32'h3,        32'h100,      2'b11, 32'h110,      1));
    vecs.push_back(mkVec("jrTop",  0, 1, 1, 3'd3, 32'hFFFF_FFFC,32'h0,  26'h0,      32'h0,        32'h0,        2'b10, 32'hFFFF_FFFC,1));
    vecs.push_back(mkVec("wrap",   0, 1, 0, 3'd0, 32'h0,        32'h0,  26'h0,      32'h0,        32'h0,        2'b00, 32'h0,        0));
    vecs.push_back(mkVec("jalrPnd",0, 0, 1, 3'd4, 32'h200,      32'h0,  26'h0,      32'h0,        32'h0,        2'b10, 32'h0,        1));
    vecs.push_back(mkVec("pndHold",0, 0, 0, 3'd0, 32'h0,        32'h0,  26'h0,      32'h0,        32'h0,        2'b00, 32'h0,        0));
    vecs.push_back(mkVec("jOvr",   0, 0, 1, 3'd1, 32'h0,        32'h0,  26'h10,     32'h0,        32'h2000_0000,2'b01, 32'h0,        1));
    vecs.push_back(mkVec("pndStl", 1, 1, 0, 3'd0, 32'h0,        32'h0,  26'h0,      32'h0,        32'h0,        2'b00, 32'h0,        0));
    vecs.push_back(mkVec("pndAcc", 0, 1, 0, 3'd0, 32'h0,        32'h0,  26'h0,      32'h0,        32'h0,        2'b00, 32'h2000_0040,0));
    vecs.push_back(mkVec("seqA",   0, 1, 0, 3'd0, 32'h0,        32'h0,  26'h0,      32'h0,        32'h0,        2'b00, 32'h2000_0044,0));
    vecs.push_back(mkVec("stlHold",1, 1, 0, 3'd0, 32'h0,        32'h0,  26'h0,      32'h0,        32'h0,        2'b00, 32'h2000_0044,0));
    vecs.push_back(mkVec("seqB",   0, 1, 0, 3'd0, 32'h0,        32'h0,  26'h0,      32'h0,        32'h0,        2'b00, 32'h2000_0048,0));

    foreach (vecs[i]) begin
      step(vecs[i]);
    end

    // JR during stall with imem not ready: parks in PEND, lands once released.
    flushSeen = 0;
    step(mkVec("jrStl",  1, 0, 1, 3'd3, 32'h400, 32'h0, 26'h0, 32'h0, 32'h0, 2'b10, 32'h2000_0048, 1));
    step(mkVec("jrHold", 1, 0, 0, 3'd0, 32'h0,   32'h0, 26'h0, 32'h0, 32'h0, 2'b00, 32'h2000_0048, 0));
    step(mkVec("jrLand", 0, 1, 0, 3'd0, 32'h0,   32'h0, 26'h0, 32'h0, 32'h0, 2'b00, 32'h400,       0));
    checkVal("jrFlushPulses", flushSeen, 32'd1);
`ifdef REDIRECT_CNT_EN
    checkVal("redirectCnt", redirect_cnt, 32'd7);
`endif

    // Asynchronous reset in the middle of a WAIT cycle.
    step(mkVec("preRst", 0, 0, 0, 3'd0, 32'h0, 32'h0, 26'h0, 32'h0, 32'h0, 2'b00, 32'h400, 0));
    #3;
    rst = 1'b0;
    #1;
    checkVal("asyncRst.imem_req", {31'h0, imem_req}, 32'h0);
    checkVal("asyncRst.pcF", pcF, 32'h0);
    checkVal("asyncRst.flush_fd", {31'h0, flush_fd}, 32'h0);
`ifdef REDIRECT_CNT_EN
    checkVal("asyncRst.cnt", redirect_cnt, 32'h0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(mkVec("reRel", 0, 1, 0, 3'd0, 32'h0, 32'h0, 26'h0, 32'h0, 32'h0, 2'b00, 32'h0, 0));
    step(mkVec("reSeq", 0, 1, 0, 3'd0, 32'h0, 32'h0, 26'h0, 32'h0, 32'h0, 2'b00, 32'h4, 0));

    if (scoreboard.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboardLeft: actual=%0d required=0", scoreboard.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
